// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the opcode control logic and the multicycle MULT/DIV unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       ControlType;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divby0flag;

    modport master (
        output ControlType, op_a, op_b,
        input  hi, lo, busy, done, divby0flag
    );

    modport slave (
        input  ControlType, op_a, op_b,
        output hi, lo, busy, done, divby0flag
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (Booth radix-2) / DIV (restoring) unit owning the HI/LO registers.
// One step per clock; hi/lo change only in the single FIN cycle, which also pulses done.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    mult_div_unit_if.slave bus
);

    localparam logic [4:0]      CT_MULT = 5'b01010;
    localparam logic [4:0]      CT_DIV  = 5'b01001;
    localparam logic [CNTW-1:0] LAST    = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t           state, next_state;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qreg;
    logic             qm1;
    logic [WIDTH:0]   mreg;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             start_mult;
    logic             start_div;
    logic             div_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] quot_out;
    logic [WIDTH-1:0] rem_out;

    assign start_mult = (bus.ControlType == CT_MULT);
    assign start_div  = (bus.ControlType == CT_DIV) && (bus.op_b != '0);
    assign div_zero   = (bus.ControlType == CT_DIV) && (bus.op_b == '0);

    // Magnitudes are unsigned, so |most negative| = 2^(W-1) is representable;
    // the divisor carries a guard bit so the W+1-bit partial remainder compares cleanly.
    assign abs_a = bus.op_a[WIDTH-1] ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
    assign abs_b = {1'b0, (bus.op_b[WIDTH-1] ? (~bus.op_b + WIDTH'(1)) : bus.op_b)};

    always_comb begin
        booth_sum = acc;
        case ({qreg[0], qm1})
            2'b01:   booth_sum = acc + mreg;
            2'b10:   booth_sum = acc - mreg;
            default: booth_sum = acc;
        endcase
    end

    assign div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    assign div_ge    = (div_shift >= mreg);
    assign quot_out  = neg_q ? (~qreg + WIDTH'(1)) : qreg;
    assign rem_out   = neg_r ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mult) begin
                    next_state = MULT;
                end else if (start_div) begin
                    next_state = DIV;
                end
            end
            MULT:    if (cnt == LAST) next_state = FIN;
            DIV:     if (cnt == LAST) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            acc            <= '0;
            qreg           <= '0;
            qm1            <= 1'b0;
            mreg           <= '0;
            is_div         <= 1'b0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            bus.hi         <= '0;
            bus.lo         <= '0;
            bus.done       <= 1'b0;
            bus.divby0flag <= 1'b0;
        end else begin
            bus.done       <= 1'b0;
            bus.divby0flag <= (state == IDLE) && div_zero;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_mult) begin
                        acc    <= '0;
                        qreg   <= bus.op_b;
                        qm1    <= 1'b0;
                        mreg   <= {bus.op_a[WIDTH-1], bus.op_a};
                        is_div <= 1'b0;
                        neg_q  <= 1'b0;
                        neg_r  <= 1'b0;
                    end else if (start_div) begin
                        acc    <= '0;
                        qreg   <= abs_a;
                        qm1    <= 1'b0;
                        mreg   <= abs_b;
                        is_div <= 1'b1;
                        neg_q  <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                        neg_r  <= bus.op_a[WIDTH-1];
                    end
                end
                MULT: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
                    qm1  <= qreg[0];
                    cnt  <= cnt + CNTW'(1);
                end
                DIV: begin
                    acc  <= div_ge ? (div_shift - mreg) : div_shift;
                    qreg <= {qreg[WIDTH-2:0], div_ge};
                    cnt  <= cnt + CNTW'(1);
                end
                FIN: begin
                    bus.done <= 1'b1;
                    if (is_div) begin
                        bus.hi <= rem_out;
                        bus.lo <= quot_out;
                    end else begin
                        bus.hi <= acc[WIDTH-1:0];
                        bus.lo <= qreg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == MULT) || (state == DIV);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products/quotients, latency, div-by-zero,
// start-while-busy, back-to-back start and asynchronous reset mid-operation.
module tb_mult_div_unit;

    localparam logic [4:0] CT_MULT = 5'b01010;
    localparam logic [4:0] CT_DIV  = 5'b01001;

    logic clk;
    logic reset_n;
    int   checks;
    int   fails;
    int   lat;
    int   busyCnt;
    int   doneSeen;
    int   flagSeen;
    int   busySeen;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNTW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the start code is seen by the next rising edge, then cleared.
    task automatic applyStimulus(input logic [4:0] ct, input logic [31:0] a, input logic [31:0] b);
        bus.ControlType = ct;
        bus.op_a        = a;
        bus.op_b        = b;
        @(negedge clk);
        bus.ControlType = 5'b00000;
    endtask

    // Counts negedges until done, bounded so a dead unit still reaches the summary.
    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [4:0] ct, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        int c;
        int bc;
        applyStimulus(ct, a, b);
        waitDone(c, bc);
        checkOutput({tag, " latency"}, c, 33);
        checkOutput({tag, " hi"}, bus.hi, expHi);
        checkOutput({tag, " lo"}, bus.lo, expLo);
    endtask

    initial begin
        checks          = 0;
        fails           = 0;
        reset_n         = 1'b0;
        bus.ControlType = 5'b00000;
        bus.op_a        = '0;
        bus.op_b        = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset hi", bus.hi, 32'h0);
        checkOutput("reset lo", bus.lo, 32'h0);
        checkOutput("reset busy", bus.busy, 32'h0);
        checkOutput("reset done", bus.done, 32'h0);
        checkOutput("reset divby0flag", bus.divby0flag, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // 7 x -3 with busy/latency profile
        applyStimulus(CT_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
        waitDone(lat, busyCnt);
        checkOutput("mult 7x-3 latency", lat, 33);
        checkOutput("mult 7x-3 busy cycles", busyCnt, 32);
        checkOutput("mult 7x-3 busy at done", bus.busy, 32'h0);
        checkOutput("mult 7x-3 hi", bus.hi, 32'hFFFF_FFFF);
        checkOutput("mult 7x-3 lo", bus.lo, 32'hFFFF_FFEB);
        @(negedge clk);
        checkOutput("done is one pulse", bus.done, 32'h0);
        checkOutput("hi held after done", bus.hi, 32'hFFFF_FFFF);

        runOp("div -7/2", CT_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("div 100/-7", CT_DIV, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
        runOp("div -100/-7", CT_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E);
        runOp("div 7/9", CT_DIV, 32'd7, 32'd9, 32'h0000_0007, 32'h0000_0000);
        runOp("mult -1x-1", CT_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        runOp("mult maxpos^2", CT_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        runOp("mult minneg^2", CT_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        runOp("div minneg/-1", CT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Preload hi=0x1234 lo=0x5678, then divide by zero
        runOp("div preload", CT_DIV, 32'h5678_1234, 32'h0001_0000, 32'h0000_1234, 32'h0000_5678);
        applyStimulus(CT_DIV, 32'd100, 32'd0);
        checkOutput("div0 flag pulse", bus.divby0flag, 32'h1);
        checkOutput("div0 busy", bus.busy, 32'h0);
        doneSeen = 0;
        flagSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen++;
            if (bus.divby0flag === 1'b1) flagSeen++;
            if (bus.busy === 1'b1) busySeen++;
        end
        checkOutput("div0 no done", doneSeen, 0);
        checkOutput("div0 flag single cycle", flagSeen, 0);
        checkOutput("div0 never busy", busySeen, 0);
        checkOutput("div0 hi unchanged", bus.hi, 32'h0000_1234);
        checkOutput("div0 lo unchanged", bus.lo, 32'h0000_5678);

        // Start while busy is ignored; operand changes after the start edge are ignored
        applyStimulus(CT_MULT, 32'd5, 32'd6);
        bus.op_a = 32'd99;
        bus.op_b = 32'd77;
        repeat (9) @(negedge clk);
        applyStimulus(CT_DIV, 32'd100, 32'd3);
        waitDone(lat, busyCnt);
        checkOutput("ignored start latency", lat, 23);
        checkOutput("ignored start hi", bus.hi, 32'h0000_0000);
        checkOutput("ignored start lo", bus.lo, 32'h0000_001E);

        // Back-to-back start issued in the done cycle
        applyStimulus(CT_MULT, 32'hFFFF_FFFF, 32'h0000_0010);
        checkOutput("b2b accepted busy", bus.busy, 32'h1);
        waitDone(lat, busyCnt);
        checkOutput("b2b latency", lat, 33);
        checkOutput("b2b hi", bus.hi, 32'hFFFF_FFFF);
        checkOutput("b2b lo", bus.lo, 32'hFFFF_FFF0);

        // Asynchronous reset in the middle of a divide
        applyStimulus(CT_DIV, 32'd1000, 32'd7);
        repeat (14) @(negedge clk);
        checkOutput("mid-div busy", bus.busy, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset hi", bus.hi, 32'h0);
        checkOutput("async reset lo", bus.lo, 32'h0);
        checkOutput("async reset busy", bus.busy, 32'h0);
        checkOutput("async reset done", bus.done, 32'h0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        doneSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen++;
            if (bus.busy === 1'b1) busySeen++;
        end
        checkOutput("post-reset no done", doneSeen, 0);
        checkOutput("post-reset idle", busySeen, 0);
        runOp("mult 3x4 after reset", CT_MULT, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
